// File: rtl/pixel_dma_writer.sv
// ============================================================================
// Module      : pixel_dma_writer
// Description : Packs 8-bit pixels into 32-bit words and writes them to
//               consecutive word addresses over the picorv32 native bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_dma_writer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        base_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  input  logic               pix_valid,
  input  logic [7:0]         pix_data,
  output logic               pix_ready,
  output logic               mem_valid,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic [3:0]         mem_wstrb,
  input  logic               mem_ready
);

  localparam logic [COUNT_W-1:0] c_ONE_WORD = COUNT_W'(1);
  localparam logic [31:0]        c_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_base;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_word_idx;
  logic [1:0]         r_byte_idx;
  logic [23:0]        r_pack;
  logic               r_abort_pend;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;

  logic w_pix_hs;
  logic w_last_word;

  assign w_pix_hs    = pix_valid & pix_ready;
  assign w_last_word = (r_word_idx == (r_count - c_ONE_WORD));

  always_comb begin
    w_state_nxt = r_state;
    pix_ready   = 1'b0;
    mem_valid   = 1'b0;
    mem_wstrb   = 4'b0000;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count != '0) ? S_FILL : S_FIN;
        end
      end
      S_FILL: begin
        // Gated by abort so no pixel is taken in the cycle the abort is seen.
        pix_ready = ~abort;
        busy      = 1'b1;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_pix_hs && (r_byte_idx == 2'd3)) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_valid = 1'b1;
        mem_wstrb = 4'b1111;
        busy      = 1'b1;
        if (mem_ready) begin
          if (abort || r_abort_pend) begin
            w_state_nxt = S_IDLE;
          end else if (w_last_word) begin
            w_state_nxt = S_FIN;
          end else begin
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_count      <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_pack       <= '0;
      r_abort_pend <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start && (word_count != '0)) begin
            r_base       <= base_addr & c_WORD_MASK;
            r_count      <= word_count;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_abort_pend <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_pix_hs) begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_pack[7:0]   <= pix_data;
              2'd1: r_pack[15:8]  <= pix_data;
              2'd2: r_pack[23:16] <= pix_data;
              default: begin
                // Bus registers are loaded once per word and then held for the whole request.
                r_mem_wdata <= {pix_data, r_pack};
                r_mem_addr  <= r_base + {{(30-COUNT_W){1'b0}}, r_word_idx, 2'b00};
              end
            endcase
          end
        end
        S_WRITE: begin
          if (abort) begin
            r_abort_pend <= 1'b1;
          end
          if (mem_ready) begin
            r_word_idx   <= r_word_idx + c_ONE_WORD;
            r_abort_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_dma_writer.sv
// ============================================================================
// Module      : tb_pixel_dma_writer
// Description : Randomized self-checking bench for pixel_dma_writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_dma_writer;

  localparam int COUNT_W = 16;

  logic               clk = 1'b0;
  logic               resetn;
  logic               start;
  logic               abort;
  logic [31:0]        base_addr;
  logic [COUNT_W-1:0] word_count;
  logic               busy;
  logic               done;
  logic               pix_valid;
  logic [7:0]         pix_data;
  logic               pix_ready;
  logic               mem_valid;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_wstrb;
  logic               mem_ready;

  pixel_dma_writer #(.COUNT_W(COUNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bubble_pct = 0;
  int rdy_delay  = 0;
  int vcnt       = 0;
  bit hs_pix     = 1'b0;

  logic [7:0]  src_q[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  acc_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_strb_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observes completed handshakes between edges; inputs are stable here.
  always @(negedge clk) begin
    hs_pix = pix_valid && pix_ready;
    if (hs_pix) acc_q.push_back(pix_data);
    if (mem_valid && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_strb_q.push_back(mem_wstrb);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
  end

  // Pixel source with random bubbles and a bus slave with a fixed wait count.
  initial begin
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pix && src_q.size() > 0) src_q.delete(0);
      pix_valid = (src_q.size() > 0) && ($urandom_range(0, 99) >= bubble_pct);
      pix_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      if (mem_valid) begin
        mem_ready = (vcnt >= rdy_delay);
        vcnt++;
      end else begin
        vcnt = 0;
        mem_ready = (rdy_delay == 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic clear_logs();
    acc_q.delete(); sent_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    wr_strb_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic load_random(int n);
    logic [7:0] p;
    for (int i = 0; i < n; i++) begin
      p = 8'($urandom);
      src_q.push_back(p);
      sent_q.push_back(p);
    end
  endtask

  task automatic pulse_start(logic [31:0] b, logic [COUNT_W-1:0] c);
    @(posedge clk); #1;
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !done) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Reference: word i lands at aligned base + 4*i and holds pixels 4i..4i+3, first pixel in the low byte.
  function automatic int model_mismatch(logic [31:0] b, int count);
    int bad;
    logic [31:0] exp_addr, exp_data;
    bad = (wr_addr_q.size() > count) ? wr_addr_q.size() - count : count - wr_addr_q.size();
    if (sent_q.size() < 4 * count) return bad + 1;
    for (int i = 0; i < count && i < wr_addr_q.size(); i++) begin
      exp_addr = (b & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_data = {sent_q[4*i+3], sent_q[4*i+2], sent_q[4*i+1], sent_q[4*i]};
      if (wr_addr_q[i] !== exp_addr || wr_data_q[i] !== exp_data || wr_strb_q[i] !== 4'hF) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, pix_ready, mem_valid, mem_wstrb} !== 8'h00)
      $display("FAIL reset_ctrl: got %b want 00000000", {busy, done, pix_ready, mem_valid, mem_wstrb});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata} !== 64'h0)
      $display("FAIL reset_bus: got addr %h data %h want 0/0", mem_addr, mem_wdata);
    else n_pass++;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    clear_logs();
    for (int i = 1; i <= 8; i++) begin
      src_q.push_back(8'(i));
      sent_q.push_back(8'(i));
    end
    pulse_start(32'h0000_0100, 2);
    @(negedge clk);
    n_checks++;
    if ({busy, pix_ready} !== 2'b11) $display("FAIL basic_launch: busy/pix_ready got %b want 11", {busy, pix_ready});
    else n_pass++;
    wait_idle(100, to);
    n_checks++;
    if (to) $display("FAIL basic_timeout: got busy want idle");
    else n_pass++;
    n_checks++;
    if (model_mismatch(32'h100, 2) != 0) $display("FAIL basic_writes: got %0d bad words want 0", model_mismatch(32'h100, 2));
    else n_pass++;
    n_checks++;
    if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h0403_0201 || wr_addr_q[1] !== 32'h104 || wr_data_q[1] !== 32'h0807_0605)
      $display("FAIL basic_values: got %0d writes want 0x04030201@100 0x08070605@104", wr_data_q.size());
    else n_pass++;
    n_checks++;
    if (done_cyc_q.size() != 1 || wr_cyc_q.size() != 2 || done_cyc_q[0] != wr_cyc_q[1] + 1)
      $display("FAIL basic_done: got %0d done pulses want 1, one cycle after last write", done_cyc_q.size());
    else n_pass++;
    n_checks++;
    if (wr_cyc_q.size() != 2 || wr_cyc_q[1] - wr_cyc_q[0] != 5)
      $display("FAIL basic_throughput: got %0d writes want 2 spaced 5 cycles", wr_cyc_q.size());
    else n_pass++;
  endtask

  task automatic test_stall();
    bit to, stable;
    int n_hi;
    logic [31:0] a0, d0;
    clear_logs();
    load_random(4);
    rdy_delay = 7;
    pulse_start(32'h0000_0040, 1);
    for (int i = 0; i < 30 && !mem_valid; i++) @(negedge clk);
    a0 = mem_addr; d0 = mem_wdata; stable = 1'b1; n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_valid) break;
      if (mem_addr !== a0 || mem_wdata !== d0 || pix_ready !== 1'b0 || mem_wstrb !== 4'hF) stable = 1'b0;
      n_hi++;
      @(negedge clk);
    end
    n_checks++;
    if (n_hi != 8) $display("FAIL stall_cycles: got %0d valid cycles want 8", n_hi);
    else n_pass++;
    n_checks++;
    if (!stable) $display("FAIL stall_stable: got changing request want stable, pix_ready=0");
    else n_pass++;
    wait_idle(50, to);
    n_checks++;
    if (to || model_mismatch(32'h40, 1) != 0)
      $display("FAIL stall_write: got %0d writes timeout=%0d want 1 correct write", wr_addr_q.size(), to);
    else n_pass++;
    rdy_delay = 0;
  endtask

  task automatic test_bubbles();
    bit to;
    clear_logs();
    load_random(16);
    bubble_pct = 40;
    pulse_start(32'h0000_0203, 3);
    wait_idle(400, to);
    repeat (10) @(negedge clk);
    n_checks++;
    if (to) $display("FAIL bubbles_timeout: got busy want idle");
    else n_pass++;
    n_checks++;
    if (acc_q.size() != 12) $display("FAIL bubbles_accepted: got %0d pixels want 12", acc_q.size());
    else n_pass++;
    n_checks++;
    if (model_mismatch(32'h203, 3) != 0 || wr_addr_q.size() != 3 || wr_addr_q[2] !== 32'h208)
      $display("FAIL bubbles_writes: got %0d bad words want 0, addresses 200/204/208", model_mismatch(32'h203, 3));
    else n_pass++;
    bubble_pct = 0;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_and_restart();
    bit to;
    clear_logs();
    pulse_start(32'h0000_0400, 0);
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b10) $display("FAIL zero_done: done/busy got %b want 10", {done, busy});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL zero_done_width: got done=%b want 0", done);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 0) $display("FAIL zero_nobus: got %0d writes want 0", wr_addr_q.size());
    else n_pass++;

    clear_logs();
    load_random(12);
    pulse_start(32'h0000_1000, 3);
    repeat (3) @(posedge clk);
    pulse_start(32'h0000_5000, 7);
    wait_idle(200, to);
    n_checks++;
    if (to || model_mismatch(32'h1000, 3) != 0)
      $display("FAIL restart_ignored: got %0d bad words timeout=%0d want 0", model_mismatch(32'h1000, 3), to);
    else n_pass++;
    n_checks++;
    if (done_cyc_q.size() != 1) $display("FAIL restart_done: got %0d pulses want 1", done_cyc_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    bit to;
    clear_logs();
    load_random(2);
    pulse_start(32'h0000_0200, 1);
    for (int i = 0; i < 30 && acc_q.size() < 2; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, pix_ready} !== 2'b00) $display("FAIL abort_fill_idle: busy/pix_ready got %b want 00", {busy, pix_ready});
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 0 || done_cyc_q.size() != 0 || acc_q.size() != 2)
      $display("FAIL abort_fill_effects: got writes %0d done %0d pixels %0d want 0/0/2",
               wr_addr_q.size(), done_cyc_q.size(), acc_q.size());
    else n_pass++;

    clear_logs();
    load_random(8);
    rdy_delay = 3;
    pulse_start(32'h0000_0300, 2);
    for (int i = 0; i < 40 && !mem_valid; i++) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle(40, to);
    repeat (5) @(negedge clk);
    n_checks++;
    if (to || wr_addr_q.size() != 1 || model_mismatch(32'h300, 1) != 0)
      $display("FAIL abort_write_completes: got %0d writes timeout=%0d want 1 correct write", wr_addr_q.size(), to);
    else n_pass++;
    n_checks++;
    if (done_cyc_q.size() != 0) $display("FAIL abort_write_nodone: got %0d pulses want 0", done_cyc_q.size());
    else n_pass++;
    n_checks++;
    if (acc_q.size() != 4) $display("FAIL abort_write_nopix: got %0d pixels want 4", acc_q.size());
    else n_pass++;
    rdy_delay = 0;
    src_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap_reset();
    bit to;
    clear_logs();
    load_random(8);
    pulse_start(32'hFFFF_FFFC, 2);
    wait_idle(100, to);
    n_checks++;
    if (to || model_mismatch(32'hFFFF_FFFC, 2) != 0 || wr_addr_q.size() != 2 || wr_addr_q[1] !== 32'h0)
      $display("FAIL wrap_writes: got %0d bad words want 0, addresses FFFFFFFC/00000000", model_mismatch(32'hFFFF_FFFC, 2));
    else n_pass++;

    clear_logs();
    load_random(4);
    rdy_delay = 10;
    pulse_start(32'h0000_0080, 1);
    for (int i = 0; i < 40 && !mem_valid; i++) begin
      @(posedge clk); #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, pix_ready, mem_valid, mem_wstrb} !== 8'h00)
      $display("FAIL async_reset_ctrl: got %b want 00000000", {busy, done, pix_ready, mem_valid, mem_wstrb});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata} !== 64'h0)
      $display("FAIL async_reset_bus: got addr %h data %h want 0/0", mem_addr, mem_wdata);
    else n_pass++;
    src_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    rdy_delay = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wr_addr_q.size() != 0)
      $display("FAIL reset_idle: got busy=%b writes=%0d want 0/0", busy, wr_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] b;
    int c;
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      b = $urandom;
      c = $urandom_range(1, 5);
      bubble_pct = $urandom_range(0, 50);
      rdy_delay  = $urandom_range(0, 3);
      load_random(4 * c);
      pulse_start(b, COUNT_W'(c));
      wait_idle(500, to);
      n_checks++;
      if (to) $display("FAIL rand_timeout[%0d]: got busy want idle", t);
      else n_pass++;
      n_checks++;
      if (model_mismatch(b, c) != 0)
        $display("FAIL rand_writes[%0d]: base %h count %0d got %0d bad words want 0", t, b, c, model_mismatch(b, c));
      else n_pass++;
      n_checks++;
      if (done_cyc_q.size() != 1) $display("FAIL rand_done[%0d]: got %0d pulses want 1", t, done_cyc_q.size());
      else n_pass++;
    end
    bubble_pct = 0;
    rdy_delay  = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bubbles();
    test_zero_and_restart();
    test_abort();
    test_wrap_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pixel_dma_writer.md
# pixel_dma_writer

Bus-initiator that drains the processed-pixel stream and stores it into system memory over the picorv32 native memory interface (mem_valid / mem_ready). It packs four 8-bit pixels per 32-bit word and issues one full-word write per packed word to consecutive word addresses starting at a programmed base. It sits between the image engine's pixel output and the SoC bus mux, so the CPU no longer has to poll 0x0200_000C for every pixel.

## Interface

- COUNT_W, 16, width of the word-count input. Maximum transfer is 2^COUNT_W − 1 words.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  launch a transfer. Sampled only in IDLE.
- abort  in  1  cancel the transfer in progress.
- base_addr  in  32  destination byte address. Bits [1:0] are ignored (forced to 0).
- word_count  in  COUNT_W  number of 32-bit words to write.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse on normal completion.
- pix_valid  in  1  input pixel valid.
- pix_data  in  8  input pixel.
- pix_ready  out  1  block accepts a pixel this cycle.
- mem_valid  out  1  bus request.
- mem_addr  out  32  bus byte address.
- mem_wdata  out  32  bus write data.
- mem_wstrb  out  4  byte strobes.
- mem_ready  in  1  bus acknowledge. May be asserted combinationally in the same cycle mem_valid rises.

## Operation

- The FSM has four states: IDLE, FILL, WRITE, FIN.
- **IDLE**
  - start=1 with word_count≠0: latch base_addr[31:2], word_count; clear word index and byte index; go to FILL.
  - start=1 with word_count=0: go to FIN. No bus activity.
- **FILL**
  - pix_ready=1.
  - Each handshake (pix_valid & pix_ready) writes pix_data into byte lane byte_idx of the pack register, little-endian: first pixel goes to [7:0], fourth to [31:24].
  - byte_idx increments modulo 4.
  - The handshake that fills lane 3 moves the FSM to WRITE.
- **WRITE**
  - pix_ready=0, mem_valid=1.
  - mem_addr = {base[31:2] + word_idx, 2'b00}, computed modulo 2^32 (wraps past 0xFFFF_FFFC).
  - mem_wdata = pack register, mem_wstrb=4'b1111.
  - mem_addr, mem_wdata and mem_wstrb are held stable until a clock edge with mem_ready=1.
  - On that edge word_idx increments. If it was the last word (word_idx = count−1), go to FIN; otherwise go to FILL.
- **FIN**
  - done=1 for exactly one cycle, then go to IDLE.
  - FIN is reached only by normal completion or word_count=0.
- **Outputs outside WRITE**
  - mem_valid=0 and mem_wstrb=0.
  - mem_addr and mem_wdata are don't-care but hold their last values.
- **busy** = 1 in FILL and WRITE; 0 in IDLE and FIN.
- **start while busy**: ignored, with no effect on latched parameters.
- **abort in IDLE or FIN**: ignored.
- **abort in FILL**: the partial word is discarded and the FSM goes to IDLE on the next edge. done is not pulsed.
- **abort in WRITE**: the request is not retracted, because the bus forbids dropping mem_valid before mem_ready. Abort is recorded; when mem_ready arrives the FSM goes to IDLE with no done pulse. A pixel is never accepted after abort is seen.
- **Simultaneous start and abort in IDLE**: start wins.
- **Reset mid-transfer**: the FSM returns to IDLE immediately, mem_valid drops asynchronously, and all state is cleared. The interrupted bus access is the bus owner's concern.

## Timing

- **Reset values**: busy=0, done=0, pix_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- start sampled at edge N → busy=1 and pix_ready=1 from N+1.
- 4th pixel of a word accepted at edge M → mem_valid=1 from M+1.
- Fastest completion: mem_ready=1 in the cycle mem_valid is high, so a bus write occupies 1 cycle.
- mem_ready seen at edge K (not last word) → mem_valid=0 and pix_ready=1 from K+1.
- Final handshake at edge K → done=1 and busy=0 during cycle K+1. IDLE from K+2, where start is accepted again.
- Maximum throughput is 1 word per 5 cycles: 4 fill cycles plus 1 write cycle.
- pix_ready does not depend combinationally on pix_valid.
- No output depends combinationally on mem_ready.

## Test plan

- **Basic transfer**
  - Stimulus: base=0x0000_0100, count=2; pixels 0x01..0x08 back-to-back; mem_ready tied 1.
  - Required: writes 0x0403_0201 @0x100 and 0x0807_0605 @0x104, wstrb=F each time; done pulses once, 1 cycle after the second write.
- **Bus stall**
  - Stimulus: count=1; mem_ready held low 7 cycles.
  - Required: mem_valid, mem_addr and mem_wdata stable for all 8 cycles; pix_ready=0 throughout; exactly one write.
- **Pixel bubbles and misalignment**
  - Stimulus: random pix_valid gaps; base=0x0000_0203; count=3.
  - Required: addresses 0x200, 0x204, 0x208; data matches pixel order; 12 pixels accepted, none after.
- **Zero count and start-while-busy**
  - Stimulus: start with count=0.
  - Required: done pulses at N+1, no mem_valid.
  - Stimulus: start pulsed mid-transfer with a different base.
  - Required: address sequence unchanged.
- **Abort**
  - Stimulus: abort after 2 pixels in FILL.
  - Required: no write, no done, busy=0 next cycle.
  - Stimulus: abort during WRITE with mem_ready delayed 3 cycles.
  - Required: that write completes, then IDLE with no done.
- **Address wrap and reset**
  - Stimulus: base=0xFFFF_FFFC, count=2.
  - Required: writes to 0xFFFF_FFFC then 0x0000_0000.
  - Stimulus: assert resetn low mid-WRITE.
  - Required: all outputs go to reset values without waiting for clk.
